// File: rtl/ama_riscv_branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_branch_resolve_pkg
//  Brief    : Shared encodings for EX-stage branch resolution: RV32I branch
//             funct3 values, resolver FSM states and the sequential PC step.
//  Revision : 1.0 - initial release
// ============================================================================
package ama_riscv_branch_resolve_pkg;

   localparam logic [2:0]  F3_BEQ  = 3'b000;
   localparam logic [2:0]  F3_BNE  = 3'b001;
   localparam logic [2:0]  F3_BLT  = 3'b100;
   localparam logic [2:0]  F3_BGE  = 3'b101;
   localparam logic [2:0]  F3_BLTU = 3'b110;
   localparam logic [2:0]  F3_BGEU = 3'b111;

   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_RESP  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // Direction from compare results; reserved encodings resolve not-taken.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt);
      logic t;
      t = 1'b0;
      case (funct3)
         F3_BEQ:           t = eq;
         F3_BNE:           t = ~eq;
         F3_BLT, F3_BLTU:  t = lt;
         F3_BGE, F3_BGEU:  t = ~lt;
         default:          t = 1'b0;
      endcase
      return t;
   endfunction

   // funct3 010/011 are not branch encodings in RV32I.
   function automatic logic branch_illegal(input logic [2:0] funct3);
      return (funct3[2:1] == 2'b01);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ama_riscv_branch_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_branch_resolve_if
//  Brief    : Request/response/redirect bundle between the EX branch resolver
//             (slave) and the issuing stage / front end (master).
//  Revision : 1.0 - initial release
// ============================================================================
interface ama_riscv_branch_resolve_if;

   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [31:0] req_pc;
   logic [31:0] req_imm;
   logic        req_pred_taken;

   logic        res_valid;
   logic        res_taken;
   logic        res_mispred;
   logic        res_illegal;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
      input  req_ready,
      input  res_valid, res_taken, res_mispred, res_illegal, redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, req_pred_taken,
      output req_ready,
      output res_valid, res_taken, res_mispred, res_illegal, redirect_valid, redirect_pc
   );

endinterface
`default_nettype wire

// File: rtl/ama_riscv_branch_compare.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_branch_compare
//  Brief    : Shared branch comparator: equality plus signed/unsigned less-than.
//  Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_branch_compare (
   input  wire logic        op_uns,
   input  wire logic [31:0] in_a,
   input  wire logic [31:0] in_b,
   output logic             op_eq,
   output logic             op_lt
);

   assign op_eq = (in_a == in_b);
   assign op_lt = op_uns ? (in_a < in_b) : ($signed(in_a) < $signed(in_b));

endmodule
`default_nettype wire

// File: rtl/ama_riscv_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : ama_riscv_branch_resolve
//  Brief    : EX-stage branch resolution sequencer. Captures one branch per
//             handshake, evaluates it on the shared comparator, reports the
//             outcome, redirects/flushes the front end on a mispredict and
//             keeps saturating branch / mispredict statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_branch_resolve
   import ama_riscv_branch_resolve_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  wire logic               clk,
   input  wire logic               rst,
   ama_riscv_branch_resolve_if.slave bus,
   output logic                    flush,
   output logic [CNT_W-1:0]        br_cnt,
   output logic [CNT_W-1:0]        mispred_cnt
);

   // Counter only has to reach FLUSH_CYCLES-2, so clog2(FLUSH_CYCLES) bits suffice.
   localparam int               FC_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   state_t            state_nxt;
   logic [FC_W-1:0]   flush_left;

   logic [2:0]        cap_funct3;
   logic [31:0]       cap_rs1;
   logic [31:0]       cap_rs2;
   logic [31:0]       cap_pc;
   logic [31:0]       cap_imm;
   logic              cap_pred;

   logic              taken_q;
   logic              mispred_q;
   logic              illegal_q;
   logic [31:0]       next_pc_q;

   logic              cmp_eq;
   logic              cmp_lt;
   logic              eval_taken;
   logic              eval_illegal;
   logic [31:0]       eval_next_pc;

   // Comparator inputs come straight from the capture registers, so it only
   // sees meaningful values once the branch has been latched.
   ama_riscv_branch_compare u_compare (
      .op_uns (cap_funct3[1]),
      .in_a   (cap_rs1),
      .in_b   (cap_rs2),
      .op_eq  (cmp_eq),
      .op_lt  (cmp_lt)
   );

   assign eval_taken   = branch_taken(cap_funct3, cmp_eq, cmp_lt);
   assign eval_illegal = branch_illegal(cap_funct3);
   assign eval_next_pc = eval_taken ? (cap_pc + cap_imm) : (cap_pc + PC_INC);

   // Latch the branch operands when a request is accepted in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_funct3 <= '0;
         cap_rs1    <= '0;
         cap_rs2    <= '0;
         cap_pc     <= '0;
         cap_imm    <= '0;
         cap_pred   <= 1'b0;
      end else if (state == ST_IDLE && bus.req_valid) begin
         cap_funct3 <= bus.req_funct3;
         cap_rs1    <= bus.req_rs1;
         cap_rs2    <= bus.req_rs2;
         cap_pc     <= bus.req_pc;
         cap_imm    <= bus.req_imm;
         cap_pred   <= bus.req_pred_taken;
      end
   end

   // Register the evaluated outcome at the end of EVAL so RESP drives flops only.
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_q   <= 1'b0;
         mispred_q <= 1'b0;
         illegal_q <= 1'b0;
         next_pc_q <= '0;
      end else if (state == ST_EVAL) begin
         taken_q   <= eval_taken;
         mispred_q <= (eval_taken != cap_pred);
         illegal_q <= eval_illegal;
         next_pc_q <= eval_next_pc;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Remaining FLUSH-state cycles after the first flush cycle issued in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_left <= '0;
      end else if (state == ST_RESP && mispred_q) begin
         flush_left <= FC_LOAD;
      end else if (state == ST_FLUSH && flush_left != '0) begin
         flush_left <= flush_left - 1'b1;
      end
   end

   // Next-state and state-decoded handshake/pulse outputs.
   always_comb begin
      state_nxt          = state;
      bus.req_ready      = 1'b0;
      bus.res_valid      = 1'b0;
      bus.redirect_valid = 1'b0;
      flush              = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            bus.res_valid = 1'b1;
            if (mispred_q) begin
               bus.redirect_valid = 1'b1;
               flush              = 1'b1;
               state_nxt          = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (flush_left == '0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.res_taken   = taken_q;
   assign bus.res_mispred = mispred_q;
   assign bus.res_illegal = illegal_q;
   assign bus.redirect_pc = next_pc_q;

   // Saturating statistics, updated once per resolved branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else if (state == ST_RESP) begin
         if (br_cnt != CNT_MAX) br_cnt <= br_cnt + 1'b1;
         if (mispred_q && mispred_cnt != CNT_MAX) mispred_cnt <= mispred_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire
